// File: rtl/sort_n_values.sv
// Sorts N unsigned WIDTH-bit values with an odd-even transposition network
// (one pass per clock), then streams them one per cycle into a FIFO.
module sort_n_values #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic               descend,
  input  logic               full,
  output logic [WIDTH-1:0]   data_out,
  output logic               push,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SORT = 3'd1;
  localparam logic [2:0] OUT  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;

  logic [2:0]       state;
  logic [WIDTH-1:0] elem     [N];
  logic [WIDTH-1:0] elem_nxt [N];
  logic             desc_r;
  logic [CW-1:0]    pass_cnt;
  logic [CW-1:0]    out_idx;

  // Pairs are disjoint within a pass, so every compare-swap reads the
  // registered elements directly. Only strictly out-of-order pairs swap,
  // which keeps equal values in their input order.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elem_nxt[i] = elem[i];
    end
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2 == 1) == pass_cnt[0]) begin
        if (desc_r ? (elem[i] < elem[i+1]) : (elem[i] > elem[i+1])) begin
          elem_nxt[i]   = elem[i+1];
          elem_nxt[i+1] = elem[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      desc_r   <= 1'b0;
      pass_cnt <= '0;
      out_idx  <= '0;
      for (int i = 0; i < N; i++) begin
        elem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              elem[i] <= data_in[i*WIDTH +: WIDTH];
            end
            desc_r   <= descend;
            pass_cnt <= '0;
            state    <= SORT;
          end
        end
        SORT: begin
          for (int i = 0; i < N; i++) begin
            elem[i] <= elem_nxt[i];
          end
          if (pass_cnt == LAST_IDX) begin
            pass_cnt <= '0;
            out_idx  <= '0;
            state    <= OUT;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        OUT: begin
          if (!full) begin
            if (out_idx == LAST_IDX) begin
              out_idx <= '0;
              state   <= DONE;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are forced idle while reset is held low, not only after the edge,
  // so an interrupted stream cannot push once more during the reset cycle.
  always_comb begin
    data_out = '0;
    push     = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    if (reset) begin
      busy = (state != IDLE);
      case (state)
        OUT: begin
          data_out = elem[out_idx];
          push     = full;
        end
        DONE: begin
          done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_n_values.sv
// Scoreboard bench for sort_n_values: N=4 main instance plus N=2 and N=5
// instances for the pairing boundary cases.
module tb_sort_n_values;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        full;
  logic        start, descend;
  logic [31:0] data_in;
  logic [7:0]  data_out;
  logic        push, busy, done;

  logic        start2, descend2;
  logic [15:0] data_in2;
  logic [7:0]  data_out2;
  logic        push2, busy2, done2;

  logic        start5, descend5;
  logic [39:0] data_in5;
  logic [7:0]  data_out5;
  logic        push5, busy5, done5;

  sort_n_values #(.WIDTH(8), .N(4)) dut (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .descend(descend), .full(full), .data_out(data_out), .push(push),
    .busy(busy), .done(done)
  );

  sort_n_values #(.WIDTH(8), .N(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .data_in(data_in2),
    .descend(descend2), .full(full), .data_out(data_out2), .push(push2),
    .busy(busy2), .done(done2)
  );

  sort_n_values #(.WIDTH(8), .N(5)) dut5 (
    .clock(clock), .reset(reset), .start(start5), .data_in(data_in5),
    .descend(descend5), .full(full), .data_out(data_out5), .push(push5),
    .busy(busy5), .done(done5)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];
  logic [7:0] exp_q5[$];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic unexpected_push(input string name, input logic [7:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: push with data %0h but no value expected", name, actual);
  endtask

  // Monitors: each push strobe consumes the oldest expected value.
  always @(negedge clock) begin
    if (push === 1'b0) begin
      if (exp_q.size() == 0) unexpected_push("n4 push", data_out);
      else check_output("n4 push data", data_out, exp_q.pop_front());
    end
  end

  always @(negedge clock) begin
    if (push2 === 1'b0) begin
      if (exp_q2.size() == 0) unexpected_push("n2 push", data_out2);
      else check_output("n2 push data", data_out2, exp_q2.pop_front());
    end
  end

  always @(negedge clock) begin
    if (push5 === 1'b0) begin
      if (exp_q5.size() == 0) unexpected_push("n5 push", data_out5);
      else check_output("n5 push data", data_out5, exp_q5.pop_front());
    end
  end

  function automatic logic done_of(input int sel);
    case (sel)
      2:       return done2;
      5:       return done5;
      default: return done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      2:       return busy2;
      5:       return busy5;
      default: return busy;
    endcase
  endfunction

  function automatic logic push_of(input int sel);
    case (sel)
      2:       return push2;
      5:       return push5;
      default: return push;
    endcase
  endfunction

  function automatic logic [7:0] data_of(input int sel);
    case (sel)
      2:       return data_out2;
      5:       return data_out5;
      default: return data_out;
    endcase
  endfunction

  function automatic int queue_size(input int sel);
    case (sel)
      2:       return exp_q2.size();
      5:       return exp_q5.size();
      default: return exp_q.size();
    endcase
  endfunction

  // Counts cycles from the start edge (that cycle is 1) to the done cycle.
  // With glitch set, start is re-pulsed with other data during SORT and OUT.
  task automatic wait_done(input int sel, input int exp_cycles, input bit glitch,
                           input logic desc);
    int  c    = 0;
    bit  seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      c++;
      if (glitch && (c == 2 || c == 6)) begin
        start   = 1'b1;
        data_in = 32'h01020304;
        descend = ~desc;
      end else if (glitch) begin
        start = 1'b0;
      end
      if (done_of(sel) === 1'b1) seen = 1'b1;
    end
    check_output($sformatf("n%0d cycles to done", sel), c, exp_cycles);
    check_output($sformatf("n%0d push during done", sel), push_of(sel), 1'b1);
    check_output($sformatf("n%0d data_out during done", sel), data_of(sel), 8'h00);
    @(negedge clock);
    check_output($sformatf("n%0d done/busy after done", sel),
                 {done_of(sel), busy_of(sel)}, 2'b00);
    check_output($sformatf("n%0d values left unpushed", sel), queue_size(sel), 0);
  endtask

  task automatic apply_stimulus(input int sel, input logic [39:0] vals,
                                input logic desc, input logic [39:0] sorted,
                                input bit glitch);
    int n = (sel == 2) ? 2 : (sel == 5) ? 5 : 4;
    for (int i = 0; i < n; i++) begin
      case (sel)
        2:       exp_q2.push_back(sorted[i*8 +: 8]);
        5:       exp_q5.push_back(sorted[i*8 +: 8]);
        default: exp_q.push_back(sorted[i*8 +: 8]);
      endcase
    end
    case (sel)
      2:       begin data_in2 = vals[15:0]; descend2 = desc; start2 = 1'b1; end
      5:       begin data_in5 = vals;       descend5 = desc; start5 = 1'b1; end
      default: begin data_in  = vals[31:0]; descend  = desc; start  = 1'b1; end
    endcase
    @(posedge clock);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    start5 = 1'b0;
    data_in  = 32'hDEADBEEF;
    data_in2 = 16'hBEEF;
    wait_done(sel, 2 * n + 1, glitch, desc);
  endtask

  initial begin
    reset    = 1'b0;
    full     = 1'b0;
    start    = 1'b0; descend  = 1'b0; data_in  = '0;
    start2   = 1'b0; descend2 = 1'b0; data_in2 = '0;
    start5   = 1'b0; descend5 = 1'b0; data_in5 = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset push", push, 1'b1);
    check_output("reset data_out", data_out, 8'h00);
    check_output("reset busy", busy, 1'b0);
    check_output("reset done", done, 1'b0);
    check_output("reset busy n2/n5", {busy2, busy5}, 2'b00);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] ascending and descending basic sort");
    apply_stimulus(4, {8'd0, 8'd3, 8'd200, 8'd3, 8'd9}, 1'b0,
                   {8'd0, 8'd200, 8'd9, 8'd3, 8'd3}, 1'b0);
    apply_stimulus(4, {8'd0, 8'd3, 8'd200, 8'd3, 8'd9}, 1'b1,
                   {8'd0, 8'd3, 8'd3, 8'd9, 8'd200}, 1'b0);

    $display("[TB] back-pressure from full");
    for (int i = 5; i <= 8; i++) exp_q.push_back(8'(i));
    data_in = {8'd8, 8'd7, 8'd6, 8'd5};
    descend = 1'b0;
    full    = 1'b1;
    start   = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_output("stall push", push, 1'b1);
      check_output("stall data_out", data_out, 8'd5);
    end
    @(posedge clock);
    #1 full = 1'b0;
    wait_done(4, 5, 1'b0, 1'b0);

    $display("[TB] start pulses while busy");
    apply_stimulus(4, {8'd0, 8'd250, 8'd1, 8'd7, 8'd7}, 1'b0,
                   {8'd0, 8'd250, 8'd7, 8'd7, 8'd1}, 1'b1);

    $display("[TB] reset during output stream");
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    data_in = {8'd2, 8'd3, 8'd1, 8'd4};
    descend = 1'b0;
    start   = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check_output("push while reset low", push, 1'b1);
    check_output("data_out while reset low", data_out, 8'h00);
    @(posedge clock);
    @(negedge clock);
    check_output("post-reset state", {push, busy, done, data_out}, {1'b1, 1'b0, 1'b0, 8'h00});
    @(posedge clock);
    #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_output("no resume after reset", busy, 1'b0);
    apply_stimulus(4, {8'd0, 8'd30, 8'd20, 8'd40, 8'd10}, 1'b1,
                   {8'd0, 8'd10, 8'd20, 8'd30, 8'd40}, 1'b0);

    $display("[TB] boundary data");
    apply_stimulus(4, 40'h00FFFFFFFF, 1'b0, 40'h00FFFFFFFF, 1'b0);
    apply_stimulus(4, {8'd0, 8'd255, 8'd0, 8'd255, 8'd0}, 1'b0,
                   {8'd0, 8'd255, 8'd255, 8'd0, 8'd0}, 1'b0);
    apply_stimulus(2, {24'd0, 8'd0, 8'd255}, 1'b0, {24'd0, 8'd255, 8'd0}, 1'b0);
    apply_stimulus(2, {24'd0, 8'd255, 8'd255}, 1'b1, {24'd0, 8'd255, 8'd255}, 1'b0);
    apply_stimulus(2, {24'd0, 8'd200, 8'd3}, 1'b1, {24'd0, 8'd3, 8'd200}, 1'b0);
    apply_stimulus(5, {8'd0, 8'd255, 8'd0, 8'd255, 8'd0}, 1'b0,
                   {8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, 1'b0);
    apply_stimulus(5, {8'd3, 8'd1, 8'd9, 8'd1, 8'd7}, 1'b1,
                   {8'd1, 8'd1, 8'd3, 8'd7, 8'd9}, 1'b0);
    apply_stimulus(5, {8'd12, 8'd25, 8'd50, 8'd100, 8'd200}, 1'b0,
                   {8'd200, 8'd100, 8'd50, 8'd25, 8'd12}, 1'b0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
